// File: rtl/tenkey_pkg.sv
// rtl/tenkey_pkg.sv - shared types and key encoding helpers for the tenkey front end
package tenkey_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_e;

  // Also used by the lock controller to mean "no key accepted yet"
  localparam logic [3:0] KEY_NONE = 4'hF;

  function automatic logic is_onehot(input logic [9:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

  function automatic logic [3:0] keyenc(input logic [9:0] v);
    logic [3:0] r;
    r = KEY_NONE;
    if (is_onehot(v)) begin
      for (int i = 0; i < 10; i++) begin
        if (v[i]) r = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tenkey_sync2.sv
// rtl/tenkey_sync2.sv - two-flop synchroniser for an asynchronous bus
module tenkey_sync2 #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Each bit is synchronised independently; the FSM tolerates skew between bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/tenkey_debounce.sv
// rtl/tenkey_debounce.sv - synchronise, debounce and validate the tenkey bus
module tenkey_debounce
  import tenkey_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] tenkey_raw,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_err,
  output logic       key_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [9:0]       sync;
  state_e           state_q;
  logic [9:0]       cap_q;
  logic [CNT_W-1:0] cnt_q;
  logic             key_valid_q;
  logic             key_err_q;
  logic             key_held_q;
  logic [3:0]       key_code_q;

  tenkey_sync2 #(.W(10)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (tenkey_raw),
    .q_o   (sync)
  );

  // Press/release debounce FSM; event pulses default low so they last one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cap_q       <= '0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
      key_held_q  <= 1'b0;
      key_code_q  <= KEY_NONE;
    end else begin
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sync != 10'd0) begin
            cap_q   <= sync;
            cnt_q   <= CNT_ONE;
            state_q <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (sync == 10'd0) begin
            state_q <= IDLE;
          end else if (sync != cap_q) begin
            // Pattern changed while settling: restart the hold count on the new pattern
            cap_q <= sync;
            cnt_q <= CNT_ONE;
          end else if (cnt_q < CNT_LAST) begin
            cnt_q <= cnt_q + CNT_ONE;
          end else begin
            state_q    <= PRESSED;
            key_held_q <= 1'b1;
            if (is_onehot(cap_q)) begin
              key_valid_q <= 1'b1;
              key_code_q  <= keyenc(cap_q);
            end else begin
              key_err_q <= 1'b1;
            end
          end
        end
        PRESSED: begin
          // Extra or changed keys during a hold are ignored until all keys lift
          if (sync == 10'd0) begin
            cnt_q   <= CNT_ONE;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          if (sync != 10'd0) begin
            state_q <= PRESSED;
          end else if (cnt_q < CNT_LAST) begin
            cnt_q <= cnt_q + CNT_ONE;
          end else begin
            state_q    <= IDLE;
            key_held_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_valid = key_valid_q;
  assign key_err   = key_err_q;
  assign key_held  = key_held_q;
  assign key_code  = key_code_q;

endmodule
